seq_mul: RTL and testbench

Parametrised sequential shift-add multiplier: generalises the fixed 3-bit combinational multiplier to any operand width, with an unsigned/signed mode select and a start/busy/done handshake. It retires one multiplier bit per clock and trades latency for area. Arithmetic datapaths that cannot afford a full array multiplier at large widths instantiate it.

---
 rtl/seq_mul_pkg.sv | 25 ++
 rtl/mag_abs.sv | 19 +
 rtl/seq_mul.sv | 143 ++++++++++++++
 tb/tb_seq_mul.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mul_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Bits needed to hold values 0..value-1 (at least 1 bit)
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mag_abs.sv
// Splits an operand into unsigned magnitude and sign. In unsigned mode the
// operand passes through untouched. The most negative value maps to
// 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
module mag_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] mag,
    output logic             sgn
);

    // Sign only matters in signed mode; magnitude is the two's complement negate
    always_comb begin
        sgn = signed_mode & x[WIDTH-1];
        mag = sgn ? -x : x;
    end

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement operands, start/busy/done handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operands, mode and sign captured on accept
// CALC  | WIDTH cycles, one partial product added per cycle
// DONE  | one cycle, done pulse, p holds the signed-corrected product
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             busy_next;
    logic             done_next;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_sgn;
    logic             b_sgn;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg;
    logic [CW-1:0]    count;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_sum;

    mag_abs #(.WIDTH(WIDTH)) u_abs_a (
        .x           (a),
        .signed_mode (signed_mode),
        .mag         (a_mag),
        .sgn         (a_sgn)
    );

    mag_abs #(.WIDTH(WIDTH)) u_abs_b (
        .x           (b),
        .signed_mode (signed_mode),
        .mag         (b_mag),
        .sgn         (b_sgn)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (count == LAST) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so busy/done are glitch-free
    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    // Registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // Partial product for the current multiplier bit and the running sum
    always_comb begin
        addend = '0;
        if (mag_b[0]) begin
            addend = {{WIDTH{1'b0}}, mag_a} << count;
        end
        acc_sum = acc + addend;
    end

    // Datapath: operand capture, shift-add iterations, product register.
    // p is loaded from the final sum on the edge entering DONE so it is
    // already valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            count <= '0;
            acc   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a <= a_mag;
                        mag_b <= b_mag;
                        neg   <= a_sgn ^ b_sgn;
                        count <= '0;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    mag_b <= mag_b >> 1;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        p <= neg ? -acc_sum : acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul at WIDTH=3, 4 and 8.
module tb_seq_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start3, sm3, busy3, done3;
    logic [2:0] a3, b3;
    logic [5:0] p3;

    logic       start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] p4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    seq_mul #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm3),
        .a(a3), .b(b3), .busy(busy3), .done(done3), .p(p3)
    );

    seq_mul #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4)
    );

    seq_mul #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );

    int n_pass  = 0;
    int n_total = 0;

    longint q3[$];
    longint q4[$];
    longint q8[$];
    int dcnt3 = 0;
    int dcnt4 = 0;
    int dcnt8 = 0;
    longint last8 = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: integer product of the operands interpreted per mode, wrapped to 2*w bits
    function automatic longint ref_mul(input int w, input longint a, input longint b, input bit sm);
        longint half;
        longint sa;
        longint sb;
        half = longint'(1) << (w - 1);
        sa = a;
        sb = b;
        if (sm && a >= half) sa = a - 2 * half;
        if (sm && b >= half) sb = b - 2 * half;
        return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Monitors: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done3) begin
            dcnt3++;
            check("w3 busy with done", busy3, 1);
            if (q3.size() == 0) check("w3 done without request (queue size)", q3.size(), 1);
            else check("w3 product", p3, q3.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            dcnt4++;
            if (q4.size() == 0) check("w4 done without request (queue size)", q4.size(), 1);
            else check("w4 product", p4, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            dcnt8++;
            if (q8.size() == 0) check("w8 done without request (queue size)", q8.size(), 1);
            else check("w8 product", p8, q8.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // W3 single op with cycle-accurate busy/done checks
    task automatic run3(input int a, input int b, input longint exp_p);
        int lat;
        start3 = 1'b1; a3 = 3'(a); b3 = 3'(b); sm3 = 1'b0;
        q3.push_back(exp_p);
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) check("w3 busy idle at start", busy3, 0);
            if (k >= 1 && k <= 4) check("w3 busy during op", busy3, 1);
            if (done3) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
            start3 = 1'b0;
        end
        check("w3 done latency", lat, 4);
        @(posedge clk); #1;
        @(negedge clk);
        check("w3 busy after done", busy3, 0);
        @(posedge clk); #1;
    endtask

    task automatic run4(input int a, input int b, input bit sm);
        int lat;
        start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); sm4 = sm;
        q4.push_back(ref_mul(4, a, b, sm));
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done4) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
            start4 = 1'b0;
        end
        check("w4 done latency", lat, 5);
        @(posedge clk); #1;
    endtask

    task automatic run8(input int a, input int b, input bit sm, input longint exp_p);
        int lat;
        start8 = 1'b1; a8 = 8'(a); b8 = 8'(b); sm8 = sm;
        q8.push_back(exp_p);
        last8 = exp_p;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        check("w8 done latency", lat, 9);
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        int ra;
        int rb;
        bit rs;
        longint e;

        rst_n = 1'b0;
        start3 = 0; sm3 = 0; a3 = 0; b3 = 0;
        start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
        start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
        #12;
        check("reset busy3", busy3, 0);
        check("reset done3", done3, 0);
        check("reset p3", p3, 0);
        check("reset busy8", busy8, 0);
        check("reset p8", p8, 0);
        check("reset p4", p4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // W3 directed unsigned
        run3(2, 2, 4);
        run3(4, 2, 8);
        run3(4, 1, 4);
        run3(1, 0, 0);
        run3(3, 3, 9);

        // Reset at cycle 3 of CALC discards the in-flight result
        start3 = 1'b1; a3 = 3'd5; b3 = 3'd3; sm3 = 1'b0;
        q3.push_back(15);
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async reset busy3", busy3, 0);
        check("async reset done3", done3, 0);
        check("async reset p3", p3, 0);
        q3.delete();
        d0 = dcnt3;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
        end
        check("no done after reset", dcnt3 - d0, 0);
        check("busy3 idle after reset", busy3, 0);
        run3(7, 6, 42);

        // W8 directed
        run8(255, 255, 0, 64'hFE01);
        run8(8'h80, 8'h80, 1, 64'h4000);
        run8(8'hFD, 8'h05, 1, 64'hFFF1);
        run8(8'hFF, 8'hFF, 1, 64'h0001);

        // W8 random
        for (int i = 0; i < 24; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, ref_mul(8, ra, rb, rs));
        end

        // start held high with operands changing every cycle: accepts every 10 cycles
        d0 = dcnt8;
        for (int c = 0; c < 50; c++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            sm8 = 1'($urandom_range(0, 1));
            start8 = 1'b1;
            if (c % 10 == 0) begin
                last8 = ref_mul(8, a8, b8, sm8);
                q8.push_back(last8);
            end
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("w8 continuous done count", dcnt8 - d0, 5);
        check("w8 continuous queue drained", q8.size(), 0);
        check("w8 continuous p held", p8, last8);

        // start pulses during CALC and DONE are ignored
        d0 = dcnt8;
        ra = int'($urandom_range(0, 255));
        rb = int'($urandom_range(0, 255));
        e = ref_mul(8, ra, rb, 1'b1);
        start8 = 1'b1; a8 = 8'(ra); b8 = 8'(rb); sm8 = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        for (int c = 1; c < 12; c++) begin
            start8 = (c == 3 || c == 5 || c == 9);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            sm8 = 1'($urandom_range(0, 1));
            if (c == 6) begin
                @(negedge clk);
                check("w8 p held during calc", p8, last8);
                check("w8 busy during calc", busy8, 1);
            end
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        check("w8 ignored starts done count", dcnt8 - d0, 1);
        check("w8 p held after done", p8, e);
        check("w8 idle after ignored starts", busy8, 0);

        // W4 exhaustive, both modes
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(x, y, 1'(s));
                end
            end
        end

        repeat (4) begin
            @(posedge clk); #1;
        end
        check("w3 queue drained", q3.size(), 0);
        check("w4 queue drained", q4.size(), 0);
        check("w8 queue drained", q8.size(), 0);
        check("w4 done count", dcnt4, 512);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
